// File: rtl/color_result_uart_tx_pkg.sv
// Shared constants, state encodings and the colour->ASCII map for the
// colour-result UART transmitter.
package color_result_uart_tx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 2604;  // 25 MHz / 9600 baud
    localparam logic [7:0]  EOL_CHAR_DEFAULT     = 8'h0A;
    localparam int unsigned DATA_BITS            = 8;

    // Classifier result codes
    localparam logic [1:0] COL_NONE  = 2'd0;
    localparam logic [1:0] COL_RED   = 2'd1;
    localparam logic [1:0] COL_GREEN = 2'd2;
    localparam logic [1:0] COL_BLUE  = 2'd3;

    // ASCII letters sent for each colour
    localparam logic [7:0] ASCII_N = 8'h4E;
    localparam logic [7:0] ASCII_R = 8'h52;
    localparam logic [7:0] ASCII_G = 8'h47;
    localparam logic [7:0] ASCII_B = 8'h42;

    // Per-byte 8N1 serialiser phases
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } byte_state_e;

    // Message sequencing: idle, a byte on the line, one-cycle EOL load gap
    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_SEND,
        MSG_NEXT
    } msg_state_e;

    function automatic logic [7:0] color_to_ascii(input logic [1:0] code);
        logic [7:0] letter;
        case (code)
            COL_NONE:  letter = ASCII_N;
            COL_RED:   letter = ASCII_R;
            COL_GREEN: letter = ASCII_G;
            COL_BLUE:  letter = ASCII_B;
            default:   letter = ASCII_N;
        endcase
        return letter;
    endfunction

endpackage

// File: rtl/color_result_uart_tx_uart_byte_tx.sv
// Single-byte 8N1 serialiser: start bit, 8 data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks. Owns the baud counter and bit index.
module color_result_uart_tx_uart_byte_tx
    import color_result_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       line_o,
    output logic       frame_end_c_o
);

    localparam int unsigned      BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    byte_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        byte_q, byte_d;
    logic              line_q, line_d;
    logic              ready_q, ready_d;

    logic              bit_end_c;
    logic [2:0]        bit_next_c;
    logic [BAUD_W-1:0] baud_step_c;

    assign bit_end_c   = (baud_q == BAUD_LAST);
    assign bit_next_c  = bit_idx_q + 3'd1;
    assign baud_step_c = bit_end_c ? '0 : baud_q + BAUD_W'(1);

    // Next-state and line value; the line register changes exactly at bit boundaries
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        line_d    = line_q;

        case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                if (load_i) begin
                    state_d   = ST_START;
                    byte_d    = byte_i;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    line_d    = 1'b0;
                end
            end
            ST_START: begin
                baud_d = baud_step_c;
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    line_d  = byte_q[0];
                end
            end
            ST_DATA: begin
                baud_d = baud_step_c;
                if (bit_end_c) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        line_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_next_c;
                        line_d    = byte_q[bit_next_c];
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_step_c;
                if (bit_end_c) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State register; reset returns the line to idle-high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            line_q    <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            line_q    <= line_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o       = ready_q;
    assign line_o        = line_q;
    assign frame_end_c_o = (state_q == ST_STOP) && bit_end_c;

endmodule

// File: rtl/color_result_uart_tx.sv
// Sends the classifier colour result to the host as "<letter><EOL>" over an
// 8N1 UART. Byte sequencing, colour mapping and busy/done live here.
module color_result_uart_tx
    import color_result_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0]  EOL_CHAR     = EOL_CHAR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [1:0] color_code,
    output logic       busy,
    output logic       done,
    output logic       uart_txd
);

    msg_state_e state_q, state_d;
    logic       byte_idx_q, byte_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       load_c;
    logic [7:0] load_byte_c;
    logic       byte_ready;
    logic       byte_line;
    logic       frame_end_c;

    // Message sequencing; the colour letter is captured by the serialiser on acceptance
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_c      = 1'b0;
        load_byte_c = EOL_CHAR;

        case (state_q)
            MSG_IDLE: begin
                if (tx_start && byte_ready) begin
                    load_c      = 1'b1;
                    load_byte_c = color_to_ascii(color_code);
                    byte_idx_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = MSG_SEND;
                end
            end
            MSG_SEND: begin
                if (frame_end_c) begin
                    if (!byte_idx_q) begin
                        state_d = MSG_NEXT;
                    end else begin
                        state_d = MSG_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            MSG_NEXT: begin
                // One idle-high cycle between the letter and the EOL byte
                load_c      = 1'b1;
                load_byte_c = EOL_CHAR;
                byte_idx_d  = 1'b1;
                state_d     = MSG_SEND;
            end
            default: begin
                state_d = MSG_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MSG_IDLE;
            byte_idx_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    color_result_uart_tx_uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_c),
        .byte_i        (load_byte_c),
        .ready_o       (byte_ready),
        .line_o        (byte_line),
        .frame_end_c_o (frame_end_c)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign uart_txd = byte_line;

endmodule
